// File: rtl/avalon_bus_router_if.sv
// Bus bundle between the CPU load/store stage, the router and the device controllers.
// Pure wiring, no latency of its own.
// Handshake is a strobe held until DataDone; slaves answer with SlvDone.
interface avalon_bus_router_if #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int DEV_BITS = 4,
    parameter int NDEV     = 3
);
    // CPU side
    logic                   ReadData;
    logic                   WriteData;
    logic [AW-1:0]          DataAddr;
    logic [DW-1:0]          BusIn;
    logic [DW-1:0]          BusOut;
    logic                   DataDone;
    logic                   BusError;
    logic [7:0]             ErrCount;
    // device side
    logic [NDEV-1:0]        SlvRead;
    logic [NDEV-1:0]        SlvWrite;
    logic [AW-DEV_BITS-1:0] SlvAddr;
    logic [DW-1:0]          SlvWdata;
    logic [NDEV*DW-1:0]     SlvRdata;
    logic [NDEV-1:0]        SlvDone;

    // Environment view: the CPU and the device controllers together.
    modport master (
        output ReadData, WriteData, DataAddr, BusIn, SlvRdata, SlvDone,
        input  BusOut, DataDone, BusError, ErrCount, SlvRead, SlvWrite, SlvAddr, SlvWdata
    );

    // Router view.
    modport slave (
        input  ReadData, WriteData, DataAddr, BusIn, SlvRdata, SlvDone,
        output BusOut, DataDone, BusError, ErrCount, SlvRead, SlvWrite, SlvAddr, SlvWdata
    );
endinterface

// File: rtl/avalon_bus_router.sv
// Decodes the top address bits to one of NDEV slaves, forwards registered strobes, returns read data.
// Latency: 2 cycles minimum to DataDone (1 for unmapped index); hung slaves are cut off after TIMEOUT cycles.
// Backpressure: master holds its strobe until DataDone; slave stalls by withholding SlvDone.
module avalon_bus_router #(
    parameter int          DW        = 16,
    parameter int          AW        = 16,
    parameter int          DEV_BITS  = 4,
    parameter int          NDEV      = 3,
    parameter int          TIMEOUT   = 256,
    parameter logic [15:0] ERR_VALUE = 16'hDEAD,
    parameter bit          STRICT    = 1'b0
) (
    input  logic                Clock,
    input  logic                Reset,
    avalon_bus_router_if.slave  bus
);
    localparam int OW = AW - DEV_BITS;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [DW-1:0] ERR_DW = DW'(ERR_VALUE);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [DEV_BITS-1:0]   idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NDEV-1:0]       slv_rd_q, slv_rd_d;
    logic [NDEV-1:0]       slv_wr_q, slv_wr_d;
    logic [OW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DW-1:0]         bus_out_q, bus_out_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [DEV_BITS-1:0]   req_idx;
    logic                  req_mapped;
    logic [NDEV-1:0]       req_onehot;
    logic                  sel_done;
    logic [DW-1:0]         sel_rdata;

    // Decode the incoming request and mux the selected slave's response.
    always_comb begin
        req_idx    = bus.DataAddr[AW-1 -: DEV_BITS];
        req_mapped = (int'(req_idx) < NDEV);
        req_onehot = '0;
        sel_done   = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NDEV; i++) begin
            req_onehot[i] = (req_idx == DEV_BITS'(i));
            if (idx_q == DEV_BITS'(i)) begin
                sel_done  = bus.SlvDone[i];
                sel_rdata = bus.SlvRdata[i*DW +: DW];
            end
        end
    end

    // Next-state and registered-output logic; done/error default low so RESP lasts one cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        slv_rd_d  = slv_rd_q;
        slv_wr_d  = slv_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bus_out_d = bus_out_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ReadData || bus.WriteData) begin
                    // Write takes priority when both strobes are high.
                    idx_d   = req_idx;
                    wr_d    = bus.WriteData;
                    addr_d  = bus.DataAddr[OW-1:0];
                    wdata_d = bus.BusIn;
                    cnt_d   = '0;
                    if (req_mapped) begin
                        slv_rd_d = bus.WriteData ? '0 : req_onehot;
                        slv_wr_d = bus.WriteData ? req_onehot : '0;
                        state_d  = ACCESS;
                    end else begin
                        bus_out_d = '0;
                        done_d    = 1'b1;
                        err_d     = STRICT;
                        state_d   = RESP;
                    end
                end
            end
            ACCESS: begin
                // Done is checked before the timeout so a late answer still wins.
                if (sel_done) begin
                    bus_out_d = wr_q ? '0 : sel_rdata;
                    slv_rd_d  = '0;
                    slv_wr_d  = '0;
                    done_d    = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    bus_out_d = ERR_DW;
                    slv_rd_d  = '0;
                    slv_wr_d  = '0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and output registers; reset drops slave strobes immediately.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            slv_rd_q  <= '0;
            slv_wr_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bus_out_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            slv_rd_q  <= slv_rd_d;
            slv_wr_q  <= slv_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bus_out_q <= bus_out_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.BusOut   = bus_out_q;
    assign bus.DataDone = done_q;
    assign bus.BusError = err_q;
    assign bus.ErrCount = err_cnt_q;
    assign bus.SlvRead  = slv_rd_q;
    assign bus.SlvWrite = slv_wr_q;
    assign bus.SlvAddr  = addr_q;
    assign bus.SlvWdata = wdata_q;
endmodule

// File: tb/tb_avalon_bus_router.sv
// Directed bench: two routers, one default (STRICT=0, TIMEOUT=256), one STRICT=1 with TIMEOUT=4.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on the DUT is bounded.
module tb_avalon_bus_router;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    avalon_bus_router_if #(.DW(16), .AW(16), .DEV_BITS(4), .NDEV(3)) b0 ();
    avalon_bus_router_if #(.DW(16), .AW(16), .DEV_BITS(4), .NDEV(3)) b1 ();

    avalon_bus_router #(.DW(16), .AW(16), .DEV_BITS(4), .NDEV(3), .TIMEOUT(256),
                        .ERR_VALUE(16'hDEAD), .STRICT(1'b0))
        dut0 (.Clock(clk), .Reset(rst), .bus(b0.slave));
    avalon_bus_router #(.DW(16), .AW(16), .DEV_BITS(4), .NDEV(3), .TIMEOUT(4),
                        .ERR_VALUE(16'hDEAD), .STRICT(1'b1))
        dut1 (.Clock(clk), .Reset(rst), .bus(b1.slave));

    task automatic test_reset();
        b0.ReadData = 0; b0.WriteData = 0; b0.DataAddr = 0; b0.BusIn = 0; b0.SlvRdata = 0; b0.SlvDone = 0;
        b1.ReadData = 0; b1.WriteData = 0; b1.DataAddr = 0; b1.BusIn = 0; b1.SlvRdata = 0; b1.SlvDone = 0;
        #1;
        checks++;
        if ({b0.BusOut, b0.DataDone, b0.BusError, b0.ErrCount, b0.SlvRead, b0.SlvWrite, b0.SlvAddr, b0.SlvWdata} !== 60'h0) begin
            errors++; $display("FAIL reset_dut0: outputs %h want 0", {b0.BusOut, b0.DataDone, b0.BusError, b0.ErrCount, b0.SlvRead, b0.SlvWrite, b0.SlvAddr, b0.SlvWdata});
        end
        checks++;
        if ({b1.BusOut, b1.DataDone, b1.BusError, b1.ErrCount, b1.SlvRead, b1.SlvWrite, b1.SlvAddr, b1.SlvWdata} !== 60'h0) begin
            errors++; $display("FAIL reset_dut1: outputs %h want 0", {b1.BusOut, b1.DataDone, b1.BusError, b1.ErrCount, b1.SlvRead, b1.SlvWrite, b1.SlvAddr, b1.SlvWdata});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_dev0();
        @(negedge clk);
        b0.ReadData = 1; b0.DataAddr = 16'h0012; b0.SlvRdata = {16'h0, 16'h0, 16'h1234}; b0.SlvDone = 3'b001;
        @(negedge clk);
        checks++;
        if ({b0.SlvRead, b0.SlvWrite, b0.DataDone, b0.SlvAddr} !== {3'b001, 3'b000, 1'b0, 12'h012}) begin
            errors++; $display("FAIL rd0_access: rd=%b wr=%b done=%b addr=%h want 001 000 0 012", b0.SlvRead, b0.SlvWrite, b0.DataDone, b0.SlvAddr);
        end
        @(negedge clk);
        checks++;
        if ({b0.DataDone, b0.BusError, b0.BusOut, b0.SlvRead} !== {1'b1, 1'b0, 16'h1234, 3'b000}) begin
            errors++; $display("FAIL rd0_resp: done=%b err=%b out=%h rd=%b want 1 0 1234 000", b0.DataDone, b0.BusError, b0.BusOut, b0.SlvRead);
        end
        b0.ReadData = 0; b0.SlvDone = 0;
        @(negedge clk);
        checks++;
        if (b0.DataDone !== 1'b0) begin
            errors++; $display("FAIL rd0_pulse: done=%b want 0", b0.DataDone);
        end
    endtask

    task automatic test_write_slow();
        @(negedge clk);
        b0.WriteData = 1; b0.DataAddr = 16'h2005; b0.BusIn = 16'h00FF;
        b0.SlvRdata = {16'h5555, 16'h0, 16'h0}; b0.SlvDone = 3'b000;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if ({b0.SlvWrite, b0.SlvRead, b0.SlvAddr, b0.SlvWdata, b0.DataDone} !== {3'b100, 3'b000, 12'h005, 16'h00FF, 1'b0}) begin
                errors++; $display("FAIL wr2_hold c%0d: wr=%b rd=%b addr=%h wd=%h done=%b want 100 000 005 00ff 0", c, b0.SlvWrite, b0.SlvRead, b0.SlvAddr, b0.SlvWdata, b0.DataDone);
            end
            if (c == 1) begin
                b0.DataAddr = 16'h1333; b0.BusIn = 16'hAAAA;
            end
            b0.SlvDone = (c == 5) ? 3'b100 : 3'b011;
        end
        @(negedge clk);
        checks++;
        if ({b0.DataDone, b0.BusError, b0.BusOut, b0.SlvWrite} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
            errors++; $display("FAIL wr2_resp: done=%b err=%b out=%h wr=%b want 1 0 0000 000", b0.DataDone, b0.BusError, b0.BusOut, b0.SlvWrite);
        end
        b0.WriteData = 0; b0.SlvDone = 0;
    endtask

    task automatic test_timeout();
        int n = 0;
        @(negedge clk);
        b0.ReadData = 1; b0.DataAddr = 16'h1000; b0.SlvDone = 3'b101;
        @(negedge clk);
        while (b0.SlvRead[1] === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 256) begin
            errors++; $display("FAIL to_strobe_len: cycles=%0d want 256", n);
        end
        checks++;
        if ({b0.DataDone, b0.BusError, b0.BusOut, b0.ErrCount, b0.SlvRead} !== {1'b1, 1'b1, 16'hDEAD, 8'd1, 3'b000}) begin
            errors++; $display("FAIL to_resp: done=%b err=%b out=%h cnt=%0d rd=%b want 1 1 dead 1 000", b0.DataDone, b0.BusError, b0.BusOut, b0.ErrCount, b0.SlvRead);
        end
        b0.ReadData = 0; b0.SlvDone = 0;
        @(negedge clk);
        checks++;
        if ({b0.DataDone, b0.BusError, b0.BusOut} !== {1'b0, 1'b0, 16'hDEAD}) begin
            errors++; $display("FAIL to_after: done=%b err=%b out=%h want 0 0 dead", b0.DataDone, b0.BusError, b0.BusOut);
        end
    endtask

    task automatic test_unmapped();
        @(negedge clk);
        b0.ReadData = 1; b0.DataAddr = 16'hF000;
        b1.ReadData = 1; b1.DataAddr = 16'hF000;
        @(negedge clk);
        checks++;
        if ({b0.DataDone, b0.BusError, b0.BusOut, b0.ErrCount, b0.SlvRead} !== {1'b1, 1'b0, 16'h0000, 8'd1, 3'b000}) begin
            errors++; $display("FAIL unmap_loose: done=%b err=%b out=%h cnt=%0d rd=%b want 1 0 0000 1 000", b0.DataDone, b0.BusError, b0.BusOut, b0.ErrCount, b0.SlvRead);
        end
        checks++;
        if ({b1.DataDone, b1.BusError, b1.BusOut, b1.ErrCount, b1.SlvRead} !== {1'b1, 1'b1, 16'h0000, 8'd1, 3'b000}) begin
            errors++; $display("FAIL unmap_strict: done=%b err=%b out=%h cnt=%0d rd=%b want 1 1 0000 1 000", b1.DataDone, b1.BusError, b1.BusOut, b1.ErrCount, b1.SlvRead);
        end
        b0.ReadData = 0; b1.ReadData = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        b0.ReadData = 1; b0.DataAddr = 16'h0001; b0.SlvRdata = {16'h0, 16'h0, 16'h0BEE}; b0.SlvDone = 3'b011;
        @(negedge clk);
        checks++;
        if ({b0.SlvRead, b0.SlvWrite} !== {3'b001, 3'b000}) begin
            errors++; $display("FAIL b2b_first: rd=%b wr=%b want 001 000", b0.SlvRead, b0.SlvWrite);
        end
        @(negedge clk);
        checks++;
        if ({b0.DataDone, b0.BusOut, b0.SlvRead, b0.SlvWrite} !== {1'b1, 16'h0BEE, 3'b000, 3'b000}) begin
            errors++; $display("FAIL b2b_done1: done=%b out=%h rd=%b wr=%b want 1 0bee 000 000", b0.DataDone, b0.BusOut, b0.SlvRead, b0.SlvWrite);
        end
        b0.WriteData = 1; b0.DataAddr = 16'h1007; b0.BusIn = 16'h4242;
        @(negedge clk);
        checks++;
        if ({b0.DataDone, b0.SlvRead, b0.SlvWrite} !== {1'b0, 3'b000, 3'b000}) begin
            errors++; $display("FAIL b2b_gap: done=%b rd=%b wr=%b want 0 000 000", b0.DataDone, b0.SlvRead, b0.SlvWrite);
        end
        @(negedge clk);
        checks++;
        if ({b0.SlvWrite, b0.SlvRead, b0.SlvAddr, b0.SlvWdata} !== {3'b010, 3'b000, 12'h007, 16'h4242}) begin
            errors++; $display("FAIL b2b_second: wr=%b rd=%b addr=%h wd=%h want 010 000 007 4242", b0.SlvWrite, b0.SlvRead, b0.SlvAddr, b0.SlvWdata);
        end
        @(negedge clk);
        checks++;
        if ({b0.DataDone, b0.BusError, b0.BusOut, b0.SlvWrite} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
            errors++; $display("FAIL b2b_done2: done=%b err=%b out=%h wr=%b want 1 0 0000 000", b0.DataDone, b0.BusError, b0.BusOut, b0.SlvWrite);
        end
        b0.ReadData = 0; b0.WriteData = 0; b0.SlvDone = 0;
        @(negedge clk);
    endtask

    task automatic test_done_at_timeout();
        @(negedge clk);
        b1.ReadData = 1; b1.DataAddr = 16'h0000; b1.SlvRdata = {16'h0, 16'h0, 16'h7777}; b1.SlvDone = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if ({b1.SlvRead, b1.DataDone} !== {3'b001, 1'b0}) begin
                errors++; $display("FAIL race_hold c%0d: rd=%b done=%b want 001 0", c, b1.SlvRead, b1.DataDone);
            end
            if (c == 4) b1.SlvDone = 3'b001;
        end
        @(negedge clk);
        checks++;
        if ({b1.DataDone, b1.BusError, b1.BusOut, b1.ErrCount} !== {1'b1, 1'b0, 16'h7777, 8'd1}) begin
            errors++; $display("FAIL race_resp: done=%b err=%b out=%h cnt=%0d want 1 0 7777 1", b1.DataDone, b1.BusError, b1.BusOut, b1.ErrCount);
        end
        b1.ReadData = 0; b1.SlvDone = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int seen = 0;
        @(negedge clk);
        b0.ReadData = 1; b0.DataAddr = 16'h1000; b0.SlvDone = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (b0.SlvRead !== 3'b010) begin
            errors++; $display("FAIL rstmid_pre: rd=%b want 010", b0.SlvRead);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({b0.SlvRead, b0.SlvWrite, b0.DataDone, b0.ErrCount, b1.ErrCount} !== {3'b000, 3'b000, 1'b0, 8'd0, 8'd0}) begin
            errors++; $display("FAIL rstmid_async: rd=%b wr=%b done=%b cnt0=%0d cnt1=%0d want 000 000 0 0 0", b0.SlvRead, b0.SlvWrite, b0.DataDone, b0.ErrCount, b1.ErrCount);
        end
        b0.ReadData = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (b0.DataDone === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rstmid_nodone: done pulses=%0d want 0", seen);
        end
    endtask

    task automatic test_err_saturate();
        for (int a = 1; a <= 300; a++) begin
            int n = 0;
            int hi = 0;
            @(negedge clk);
            b1.ReadData = 1; b1.DataAddr = 16'h1000; b1.SlvDone = 0;
            @(negedge clk);
            while (b1.DataDone !== 1'b1 && n < 20) begin
                if (b1.SlvRead[1] === 1'b1) hi++;
                n++;
                @(negedge clk);
            end
            b1.ReadData = 0;
            if (n >= 20) begin
                checks++; errors++;
                $display("FAIL sat_wait a%0d: no DataDone after %0d cycles, want done", a, n);
            end
            if (a == 1) begin
                checks++;
                if ({hi[7:0], b1.ErrCount, b1.BusError, b1.BusOut} !== {8'd4, 8'd1, 1'b1, 16'hDEAD}) begin
                    errors++; $display("FAIL sat_first: strobe=%0d cnt=%0d err=%b out=%h want 4 1 1 dead", hi, b1.ErrCount, b1.BusError, b1.BusOut);
                end
            end
            if (a == 255) begin
                checks++;
                if (b1.ErrCount !== 8'd255) begin
                    errors++; $display("FAIL sat_255: cnt=%0d want 255", b1.ErrCount);
                end
            end
            if (a == 300) begin
                checks++;
                if ({b1.ErrCount, b1.BusError} !== {8'd255, 1'b1}) begin
                    errors++; $display("FAIL sat_300: cnt=%0d err=%b want 255 1", b1.ErrCount, b1.BusError);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_dev0();
        test_write_slow();
        test_timeout();
        test_unmapped();
        test_back_to_back();
        test_done_at_timeout();
        test_reset_mid_access();
        test_err_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/avalon_bus_router.md
Name: avalon_bus_router

Overview:
- Parametrised successor to the processor's data-bus decoder.
- Sits between the CPU load/store stage and N memory-mapped device controllers (memory, on-chip accelerators, IO).
- Decodes the top DEV_BITS of the address, forwards registered strobes to one slave, and waits for that slave's done.
- Returns registered read data with a one-cycle done pulse; a per-access timeout plus error flag/counter stops a hung slave from stalling the pipeline forever.

Parameters:
DW, 16, data width of BusIn/BusOut and each slave read port
AW, 16, address width of DataAddr
DEV_BITS, 4, number of top address bits used as device index
NDEV, 3, number of attached slave channels (1..2**DEV_BITS)
TIMEOUT, 256, max cycles in ACCESS before forced error completion (>=2)
ERR_VALUE, 16'hDEAD, BusOut value returned on timeout (truncated/zero-extended to DW)
STRICT, 0, 1 = access to unmapped device index also flags BusError

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-high reset
ReadData  input  1  master read strobe, held until DataDone seen
WriteData  input  1  master write strobe, held until DataDone seen
DataAddr  input  AW  master address
BusIn  input  DW  master write data
BusOut  output  DW  registered read data, valid while DataDone=1
DataDone  output  1  one-cycle completion pulse
BusError  output  1  one-cycle pulse coincident with DataDone on failed access
ErrCount  output  8  saturating count of BusError pulses
SlvRead  output  NDEV  per-slave read strobe (one-hot or zero)
SlvWrite  output  NDEV  per-slave write strobe (one-hot or zero)
SlvAddr  output  AW-DEV_BITS  latched address offset to slaves
SlvWdata  output  DW  latched write data to slaves
SlvRdata  input  NDEV*DW  flattened slave read data, slave i at [i*DW +: DW]
SlvDone  input  NDEV  per-slave done (combinational from slave allowed)

Behaviour:
- Reset (async): state=IDLE; all outputs 0 (BusOut, DataDone, BusError, ErrCount, SlvRead, SlvWrite, SlvAddr, SlvWdata); timeout counter 0.
- States IDLE, ACCESS, RESP.
- IDLE:
  - On ReadData|WriteData: latch index idx=DataAddr[AW-1 -: DEV_BITS], offset, BusIn and op.
  - Both strobes high: treated as write.
  - idx<NDEV: go to ACCESS, assert SlvRead[idx]/SlvWrite[idx] (registered), counter=0.
  - idx>=NDEV: go directly to RESP with BusOut=0, BusError=STRICT.
- ACCESS:
  - Strobe to selected slave held constant; master address/data changes ignored.
  - Each cycle with SlvDone[idx]=1: capture SlvRdata[idx] into BusOut (writes capture 0); drop slave strobes; go to RESP.
  - Otherwise counter++. When counter==TIMEOUT-1 and no done: drop strobes, BusOut=ERR_VALUE, BusError=1 for RESP, go to RESP.
  - SlvDone from non-selected slaves ignored.
- RESP:
  - DataDone=1 (and BusError if flagged) for exactly one cycle, then IDLE.
  - BusOut holds its value until the next RESP.
- Latency: minimum 2 cycles from strobe sampled in IDLE to DataDone (slave done in first ACCESS cycle); unmapped access is 1 cycle.
- Master deasserts strobes the cycle after DataDone; a strobe still high in IDLE starts a new access (back-to-back allowed, no dead cycle required beyond RESP).
- ErrCount increments on each BusError pulse, saturates at 255, cleared only by Reset.
- Simultaneous slave done and timeout on the same cycle: done wins, no error.
- Reset mid-ACCESS: strobes drop asynchronously, no DataDone emitted, pending transaction discarded.

Test Plan:
- Read dev 0 (addr 0x0012), slave 0 returns 0x1234 with done in first ACCESS cycle -> SlvRead=001 for 1 cycle, DataDone at cycle 2, BusOut=0x1234, BusError=0.
- Write dev 2 (addr 0x2005, BusIn=0x00FF), slave 2 done after 5 cycles -> SlvWrite=100, SlvAddr=0x005, SlvWdata=0x00FF held 5 cycles, DataDone cycle 6, BusOut=0.
- Read dev 1, slave never done, TIMEOUT=256 -> strobe drops after 256 ACCESS cycles, DataDone+BusError pulse, BusOut=0xDEAD, ErrCount=1.
- Read addr 0xF000 with STRICT=0 then STRICT=1 -> DataDone 1 cycle later, BusOut=0; BusError 0 vs 1.
- Back-to-back: read dev0 then write dev1 with strobes held continuously -> two DataDone pulses, no overlapping slave strobes; both ReadData+WriteData high -> write issued.
- Assert Reset during ACCESS -> SlvRead/SlvWrite go 0 immediately, no DataDone, ErrCount=0; 300 timeouts -> ErrCount saturates at 255.
